hyperbus_burst_splitter: RTL and testbench
==========================================

Name: hyperbus_burst_splitter

Overview:
- Sits between the AXI front-end and the HyperBus PHY/command FSM.
- Converts one AXI-style burst request (address, len, size) into a sequence of HyperBus transfers.
- Each transfer has a 16-bit word count. No transfer exceeds MaxBurstWords, and no transfer crosses a chip boundary.
- Each transfer drives a one-hot chip select, so NumChips devices share one PHY.

Parameters:
AddrWidth, 32, byte address width of request
LenWidth, 8, width of AXI len field (beats-1)
NumChips, 2, number of HyperBus chips; power of two, >=1
ChipAddrWidth, 23, log2 of bytes per chip (8 MiB)
MaxBurstWords, 256, max 16-bit words per PHY transfer; power of two
WordCntWidth, 16, width of word counters and xfer_words_o

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  AddrWidth  start byte address
req_len_i  in  LenWidth  beats minus one
req_size_i  in  3  log2 bytes per beat (0..4)
req_write_i  in  1  1=write, 0=read
xfer_valid_o  out  1  transfer descriptor valid
xfer_ready_i  in  1  PHY accepts descriptor
xfer_cs_o  out  NumChips  one-hot chip select
xfer_addr_o  out  ChipAddrWidth-1  word address within chip
xfer_words_o  out  WordCntWidth  words in this transfer (>=1)
xfer_write_o  out  1  copy of req_write_i
xfer_last_o  out  1  final transfer of current request
busy_o  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, ISSUE.

Reset:
- Synchronous, on rst_i: state=IDLE.
- req_ready_o=1 while in IDLE, i.e. from the first cycle after reset.
- xfer_valid_o=0, xfer_cs_o=0, xfer_addr_o=0, xfer_words_o=0, xfer_write_o=0, xfer_last_o=0, busy_o=0.
- rst_i mid-operation aborts the request; no further descriptors are issued.

IDLE:
- req_ready_o=1.
- On req_valid_i, register the request and compute:
  - bytes = (len+1)<<size
  - end_byte = addr+bytes-1
  - total_words = (end_byte>>1) - (addr>>1) + 1 (odd start/end bytes round to a full word)
  - cur_word = addr>>1
  - chip = addr[ChipAddrWidth +: log2(NumChips)]; higher address bits are ignored.
- Next state: ISSUE.

ISSUE:
- req_ready_o=0; xfer_valid_o=1 starting the cycle after acceptance (latency 1 cycle).
- Piece size: piece = min(remaining, MaxBurstWords, 2^(ChipAddrWidth-1) - word_in_chip).
- Piece computation is registered: piece, address and cs all come from flops.
- All xfer_* outputs hold stable while xfer_valid_o & !xfer_ready_i.
- xfer_last_o=1 iff piece == remaining.

On each handshake:
- If not last: advance word_in_chip by piece and decrement remaining by piece.
  - If the chip boundary is reached, word_in_chip wraps to 0 and chip increments.
  - Chip NumChips-1 wraps to chip 0.
  - The next descriptor is valid in the next cycle; xfer_valid_o may stay high back-to-back.
- If last: go to IDLE. xfer_valid_o=0 and req_ready_o=1 the next cycle.

Other rules:
- No new request is accepted while in ISSUE.
- xfer_cs_o is one-hot whenever xfer_valid_o=1.
- Arithmetic:
  - Unsigned, with no overflow at the defaults (max 4096 bytes → 2049 words).
  - word_in_chip is ChipAddrWidth-1 bits wide.
  - The distance to the chip boundary is computed one bit wider.
- req_size_i > 4: behaviour is undefined. An assertion flags it in simulation.

Test Plan:
1. addr 0xA00, len 255, size 4, write (4096 B):
   - → 8 descriptors, each words=256, cs=01.
   - word addrs 0x500, 0x600, …, 0xC00; xfer_last_o only on the 8th.
   - req_ready_o returns 1 the cycle after the 8th handshake.
2. addr 0x902, len 2, size 2, read:
   - → one descriptor: addr 0x481, words=6, last=1, write=0.
   - Also addr 0x501, len 0, size 0 → addr 0x280, words=1.
3. Chip boundary: addr 0x7F_FFF0, len 1, size 4 (32 B):
   - → descriptor A: cs=01, addr 0x3F_FFF8, words=8, last=0.
   - → descriptor B: cs=10, addr 0, words=8, last=1.
   - Also addr 0xFF_FFFC, len 0, size 3 → cs=10 words=2, then cs=01 addr 0 words=2 (wrap).
4. Backpressure: during test 1, hold xfer_ready_i=0 for 5 cycles on the 3rd descriptor:
   - → addr 0x700 / words 256 / cs held constant.
   - req_ready_o=0 and busy_o=1 throughout.
   - A req_valid_i pulse during this window is not accepted.
5. Reset mid-op: assert rst_i for 1 cycle after the 3rd handshake of test 1:
   - → next cycle xfer_valid_o=0, req_ready_o=1, all outputs at reset values.
   - A new request (addr 0x100, len 0, size 4) yields a single descriptor: addr 0x80, words 8.
6. Back-to-back: two requests with xfer_ready_i tied 1 (0x0 len 0 size 4, then 0x20 len 0 size 4):
   - → descriptors appear at cycles N+1 and N+3.
   - One IDLE cycle separates the requests.

Source files
------------

// File: rtl/hyperbus_burst_splitter.sv
// Purpose : split one AXI-style burst (addr, len, size) into HyperBus word transfers that never
//           exceed MaxBurstWords nor cross a chip boundary; each transfer carries a one-hot chip select.
// Latency : first descriptor valid 1 cycle after req acceptance; later descriptors back-to-back.
// Backpr. : descriptors hold stable while xfer_valid_o & !xfer_ready_i; no new request accepted while busy.
// Ports   : clk_i/rst_i (sync, active-high); req_* request channel (valid/ready);
//           xfer_* descriptor channel (valid/ready, cs, word addr, word count, write, last); busy_o.
module hyperbus_burst_splitter #(
  parameter int AddrWidth     = 32,
  parameter int LenWidth      = 8,
  parameter int NumChips      = 2,
  parameter int ChipAddrWidth = 23,
  parameter int MaxBurstWords = 256,
  parameter int WordCntWidth  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AddrWidth-1:0]       req_addr_i,
  input  logic [LenWidth-1:0]        req_len_i,
  input  logic [2:0]                 req_size_i,
  input  logic                       req_write_i,
  output logic                       xfer_valid_o,
  input  logic                       xfer_ready_i,
  output logic [NumChips-1:0]        xfer_cs_o,
  output logic [ChipAddrWidth-2:0]   xfer_addr_o,
  output logic [WordCntWidth-1:0]    xfer_words_o,
  output logic                       xfer_write_o,
  output logic                       xfer_last_o,
  output logic                       busy_o
);

  localparam int WicW     = ChipAddrWidth - 1;
  localparam int ChipIdxW = (NumChips > 1) ? $clog2(NumChips) : 1;
  localparam int CmpW     = (WordCntWidth > WicW + 1) ? WordCntWidth : WicW + 1;

  typedef enum logic {IDLE, ISSUE} state_e;
  typedef logic [AddrWidth:0] addr_ext_t;

  state_e                  state_q, state_d;
  logic [ChipIdxW-1:0]     chip_q, chip_d;
  logic [WicW-1:0]         wic_q, wic_d;
  logic [WordCntWidth-1:0] rem_q, rem_d;
  logic [WordCntWidth-1:0] piece_q, piece_d;
  logic                    last_q, last_d;
  logic                    write_q, write_d;

  addr_ext_t               bytes_w, end_w, total_w;
  logic [WicW:0]           adv_w, dist_w;
  logic [CmpW-1:0]         pmin_w;
  logic                    issue_w;

  always_comb begin
    state_d = state_q;
    chip_d  = chip_q;
    wic_d   = wic_q;
    rem_d   = rem_q;
    write_d = write_q;
    // Request geometry; one bit wider than the address so end_byte never wraps.
    bytes_w = (addr_ext_t'(req_len_i) + addr_ext_t'(1)) << req_size_i;
    end_w   = addr_ext_t'(req_addr_i) + bytes_w - addr_ext_t'(1);
    total_w = (end_w >> 1) - (addr_ext_t'(req_addr_i) >> 1) + addr_ext_t'(1);
    adv_w   = (WicW + 1)'(wic_q) + (WicW + 1)'(piece_q);

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = ISSUE;
          chip_d  = ChipIdxW'(req_addr_i >> ChipAddrWidth) & ChipIdxW'(NumChips - 1);
          wic_d   = req_addr_i[ChipAddrWidth-1:1];
          rem_d   = WordCntWidth'(total_w);
          write_d = req_write_i;
        end
      end
      ISSUE: begin
        if (xfer_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            // A piece never passes the boundary, so the carry out marks an exact hit.
            wic_d = adv_w[WicW-1:0];
            if (adv_w[WicW]) chip_d = (chip_q + ChipIdxW'(1)) & ChipIdxW'(NumChips - 1);
            rem_d = rem_q - piece_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Next piece is computed from the next-cycle pointers so it can be registered.
    dist_w = {1'b1, {WicW{1'b0}}} - {1'b0, wic_d};
    pmin_w = CmpW'(rem_d);
    if (CmpW'(MaxBurstWords) < pmin_w) pmin_w = CmpW'(MaxBurstWords);
    if (CmpW'(dist_w) < pmin_w)        pmin_w = CmpW'(dist_w);
    piece_d = WordCntWidth'(pmin_w);
    last_d  = (piece_d == rem_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      chip_q  <= '0;
      wic_q   <= '0;
      rem_q   <= '0;
      piece_q <= '0;
      last_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chip_q  <= chip_d;
      wic_q   <= wic_d;
      rem_q   <= rem_d;
      piece_q <= piece_d;
      last_q  <= last_d;
      write_q <= write_d;
    end
  end

  // Descriptor fields are forced to zero outside ISSUE so idle/reset outputs are clean.
  assign issue_w      = (state_q == ISSUE);
  assign req_ready_o  = !issue_w;
  assign busy_o       = issue_w;
  assign xfer_valid_o = issue_w;
  assign xfer_cs_o    = issue_w ? (NumChips'(1) << chip_q) : '0;
  assign xfer_addr_o  = issue_w ? wic_q : '0;
  assign xfer_words_o = issue_w ? piece_q : '0;
  assign xfer_write_o = issue_w & write_q;
  assign xfer_last_o  = issue_w & last_q;

  a_req_size_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (req_valid_i && req_ready_o) |-> (req_size_i <= 3'd4));

endmodule

// File: tb/tb_hyperbus_burst_splitter.sv
// Purpose : randomized + directed check of hyperbus_burst_splitter against a word-walking reference model.
// Latency : inputs driven and outputs sampled on the falling edge of clk_i.
// Backpr. : random and directed xfer_ready_i stalls exercise descriptor hold.
module tb_hyperbus_burst_splitter;

  localparam longint CHIP_WORDS = 64'd1 << 22;
  localparam longint NCHIPS     = 2;
  localparam longint MAXW       = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [7:0]  req_len_i = '0;
  logic [2:0]  req_size_i = '0;
  logic        req_write_i = 1'b0;
  logic        xfer_valid_o;
  logic        xfer_ready_i = 1'b0;
  logic [1:0]  xfer_cs_o;
  logic [21:0] xfer_addr_o;
  logic [15:0] xfer_words_o;
  logic        xfer_write_o;
  logic        xfer_last_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  cs;
    logic [21:0] addr;
    logic [15:0] words;
    logic        last;
  } desc_t;

  desc_t exp_q[$];
  desc_t obs_q[$];

  hyperbus_burst_splitter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_size_i(req_size_i),
    .req_write_i(req_write_i),
    .xfer_valid_o(xfer_valid_o), .xfer_ready_i(xfer_ready_i),
    .xfer_cs_o(xfer_cs_o), .xfer_addr_o(xfer_addr_o), .xfer_words_o(xfer_words_o),
    .xfer_write_o(xfer_write_o), .xfer_last_o(xfer_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Walk the request in global word units; the chip is the word address bit above the chip range.
  task automatic model(input logic [31:0] addr, input int len, input int size);
    longint start_b, end_b, gw, rem, wic, chip, piece;
    desc_t d;
    start_b = longint'(addr);
    end_b   = start_b + (longint'(len + 1) << size) - 1;
    gw      = start_b >> 1;
    rem     = (end_b >> 1) - gw + 1;
    exp_q.delete();
    while (rem > 0) begin
      wic   = gw % CHIP_WORDS;
      chip  = (gw / CHIP_WORDS) % NCHIPS;
      piece = rem;
      if (piece > MAXW) piece = MAXW;
      if (piece > CHIP_WORDS - wic) piece = CHIP_WORDS - wic;
      d.cs    = 2'(1 << chip);
      d.addr  = 22'(wic);
      d.words = 16'(piece);
      d.last  = (piece == rem);
      exp_q.push_back(d);
      gw  += piece;
      rem -= piece;
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_xvld"}, 64'(xfer_valid_o), 64'd0);
    chk({tag, "_rrdy"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Issue one request, drain all descriptors, compare each against the model.
  // Descriptor stall_at is held off for stall_n cycles with a req_valid_i pulse inside the window.
  task automatic run_req(input logic [31:0] addr, input int len, input int size, input logic wr,
                         input int stall_at, input int stall_n, input bit rnd);
    desc_t o;
    bit    stall;
    int    waited;
    model(addr, len, size);
    chk("req_rdy_idle", 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1; req_addr_i = addr; req_len_i = 8'(len); req_size_i = 3'(size);
    req_write_i = wr;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      waited = 0;
      forever begin
        chk("xfer_vld", 64'(xfer_valid_o), 64'd1);
        chk("xfer_cs", 64'(xfer_cs_o), 64'(exp_q[i].cs));
        chk("xfer_addr", 64'(xfer_addr_o), 64'(exp_q[i].addr));
        chk("xfer_words", 64'(xfer_words_o), 64'(exp_q[i].words));
        chk("xfer_last", 64'(xfer_last_o), 64'(exp_q[i].last));
        chk("xfer_write", 64'(xfer_write_o), 64'(wr));
        if (i == stall_at && waited < stall_n) stall = 1'b1;
        else if (rnd) stall = ($urandom_range(0, 3) == 0);
        else stall = 1'b0;
        if (stall) begin
          chk("stall_rrdy", 64'(req_ready_o), 64'd0);
          chk("stall_busy", 64'(busy_o), 64'd1);
        end
        if (stall && i == stall_at && waited == 0) begin
          req_valid_i = 1'b1; req_addr_i = 32'h0000_4000; req_len_i = 8'd0; req_size_i = 3'd0;
        end else begin
          req_valid_i = 1'b0;
        end
        if (!stall) begin
          o.cs = xfer_cs_o; o.addr = xfer_addr_o; o.words = xfer_words_o; o.last = xfer_last_o;
          obs_q.push_back(o);
        end
        xfer_ready_i = !stall;
        @(negedge clk_i);
        waited++;
        if (!stall) break;
      end
    end
    req_valid_i  = 1'b0;
    xfer_ready_i = 1'b0;
    check_idle("done");
  endtask

  initial begin
    logic [31:0] a;
    // Reset state
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle("reset");
    chk("reset_cs", 64'(xfer_cs_o), 64'd0);
    chk("reset_addr", 64'(xfer_addr_o), 64'd0);
    chk("reset_words", 64'(xfer_words_o), 64'd0);
    chk("reset_last", 64'(xfer_last_o), 64'd0);
    chk("reset_write", 64'(xfer_write_o), 64'd0);

    // 4 KiB write, with a 5-cycle stall and a rejected request pulse on the 3rd descriptor
    run_req(32'h0000_0A00, 255, 4, 1'b1, 2, 5, 1'b0);
    chk("t1_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < obs_q.size(); i++) begin
      chk("t1_addr", 64'(obs_q[i].addr), 64'h500 + 64'(i) * 64'h100);
      chk("t1_words", 64'(obs_q[i].words), 64'd256);
      chk("t1_cs", 64'(obs_q[i].cs), 64'd1);
      chk("t1_last", 64'(obs_q[i].last), 64'(i == 7));
    end

    // Odd / unaligned single-descriptor reads
    run_req(32'h0000_0902, 2, 2, 1'b0, -1, 0, 1'b0);
    chk("t2a_count", 64'(obs_q.size()), 64'd1);
    chk("t2a_addr", 64'(obs_q[0].addr), 64'h481);
    chk("t2a_words", 64'(obs_q[0].words), 64'd6);
    chk("t2a_last", 64'(obs_q[0].last), 64'd1);
    run_req(32'h0000_0501, 0, 0, 1'b0, -1, 0, 1'b0);
    chk("t2b_addr", 64'(obs_q[0].addr), 64'h280);
    chk("t2b_words", 64'(obs_q[0].words), 64'd1);

    // Chip boundary and wrap from the last chip back to chip 0
    run_req(32'h007F_FFF0, 1, 4, 1'b1, -1, 0, 1'b0);
    chk("t3a_count", 64'(obs_q.size()), 64'd2);
    chk("t3a_cs0", 64'(obs_q[0].cs), 64'd1);
    chk("t3a_addr0", 64'(obs_q[0].addr), 64'h3F_FFF8);
    chk("t3a_words0", 64'(obs_q[0].words), 64'd8);
    chk("t3a_last0", 64'(obs_q[0].last), 64'd0);
    chk("t3a_cs1", 64'(obs_q[1].cs), 64'd2);
    chk("t3a_addr1", 64'(obs_q[1].addr), 64'd0);
    chk("t3a_words1", 64'(obs_q[1].words), 64'd8);
    chk("t3a_last1", 64'(obs_q[1].last), 64'd1);
    run_req(32'h00FF_FFFC, 0, 3, 1'b0, -1, 0, 1'b0);
    chk("t3b_count", 64'(obs_q.size()), 64'd2);
    chk("t3b_cs0", 64'(obs_q[0].cs), 64'd2);
    chk("t3b_words0", 64'(obs_q[0].words), 64'd2);
    chk("t3b_cs1", 64'(obs_q[1].cs), 64'd1);
    chk("t3b_addr1", 64'(obs_q[1].addr), 64'd0);
    chk("t3b_words1", 64'(obs_q[1].words), 64'd2);

    // Reset after the 3rd handshake of the 4 KiB burst
    req_valid_i = 1'b1; req_addr_i = 32'h0000_0A00; req_len_i = 8'd255; req_size_i = 3'd4;
    req_write_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    xfer_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    xfer_ready_i = 1'b0;
    chk("t5_pre_vld", 64'(xfer_valid_o), 64'd1);
    chk("t5_pre_addr", 64'(xfer_addr_o), 64'h800);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_idle("t5_rst");
    chk("t5_cs", 64'(xfer_cs_o), 64'd0);
    chk("t5_words", 64'(xfer_words_o), 64'd0);
    run_req(32'h0000_0100, 0, 4, 1'b0, -1, 0, 1'b0);
    chk("t5_count", 64'(obs_q.size()), 64'd1);
    chk("t5_addr", 64'(obs_q[0].addr), 64'h80);
    chk("t5_words", 64'(obs_q[0].words), 64'd8);

    // Back-to-back requests with xfer_ready_i tied high
    xfer_ready_i = 1'b1;
    req_valid_i = 1'b1; req_addr_i = 32'h0; req_len_i = 8'd0; req_size_i = 3'd4;
    req_write_i = 1'b0;
    @(negedge clk_i);                                    // N+1
    chk("t6_d0_vld", 64'(xfer_valid_o), 64'd1);
    chk("t6_d0_addr", 64'(xfer_addr_o), 64'd0);
    chk("t6_busy_rrdy", 64'(req_ready_o), 64'd0);
    req_addr_i = 32'h20;
    @(negedge clk_i);                                    // N+2: idle gap
    chk("t6_gap_vld", 64'(xfer_valid_o), 64'd0);
    chk("t6_gap_rrdy", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);                                    // N+3
    req_valid_i = 1'b0;
    chk("t6_d1_vld", 64'(xfer_valid_o), 64'd1);
    chk("t6_d1_addr", 64'(xfer_addr_o), 64'h10);
    chk("t6_d1_words", 64'(xfer_words_o), 64'd8);
    chk("t6_d1_last", 64'(xfer_last_o), 64'd1);
    @(negedge clk_i);
    xfer_ready_i = 1'b0;
    check_idle("t6_end");

    // Randomized requests, biased toward chip boundaries and the top of the address space
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = (32'($urandom_range(1, 8)) << 23) - 32'($urandom_range(0, 700));
        default: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 5000));
      endcase
      run_req(a, int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1'($urandom),
              -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
